// File: rtl/imm_gen_pipe_pkg.sv
// Shared opcode constants and the immediate-format tag for the immediate generator.
package imm_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_Z = 3'd6
  } imm_fmt_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Fetch-to-decode stream carrying raw instructions in and decoded immediates out.
interface imm_gen_pipe_if #(parameter int XLEN = 32);
  import imm_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  imm_fmt_t        out_fmt;
  logic [31:0]     out_inst;
  logic            out_illegal;

  modport master (
    output in_valid, in_inst, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_inst, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_inst, out_illegal
  );

endinterface

// File: rtl/imm_gen_pipe_decode.sv
// Combinational RISC-V immediate decoder for every base format.
// Defining IMM_ZICSR_EN makes CSR*I instructions report fmt Z with the uimm field.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_t        fmt_o,
  output logic            illegal_o
);

  localparam bit Rv64 = (XLEN == 64);

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'(signed'(v));
  endfunction

  logic [31:0] immI, immS, immB, immU, immJ;

  assign immI = {{20{inst_i[31]}}, inst_i[31:20]};
  assign immS = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign immB = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign immU = {inst_i[31:12], 12'b0};
  assign immJ = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  always_comb begin
    imm_o     = '0;
    fmt_o     = FMT_R;
    illegal_o = 1'b0;
    case (inst_i[6:0])
      OPC_LUI, OPC_AUIPC: begin
        fmt_o = FMT_U;
        imm_o = sext32(immU);
      end
      OPC_JAL: begin
        fmt_o = FMT_J;
        imm_o = sext32(immJ);
      end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
        fmt_o = FMT_I;
        imm_o = sext32(immI);
      end
      OPC_OP_IMM_32: begin
        if (Rv64) begin
          fmt_o = FMT_I;
          imm_o = sext32(immI);
        end else begin
          illegal_o = 1'b1;
        end
      end
      OPC_STORE: begin
        fmt_o = FMT_S;
        imm_o = sext32(immS);
      end
      OPC_BRANCH: begin
        fmt_o = FMT_B;
        imm_o = sext32(immB);
      end
      OPC_OP, OPC_MISC_MEM: begin
        fmt_o = FMT_R;
      end
      OPC_OP_32: begin
        illegal_o = !Rv64;
      end
      OPC_SYSTEM: begin
`ifdef IMM_ZICSR_EN
        if (inst_i[14]) begin
          fmt_o = FMT_Z;
          imm_o = XLEN'(inst_i[19:15]);
        end else begin
          fmt_o = FMT_I;
          imm_o = sext32(immI);
        end
`else
        fmt_o = FMT_I;
        imm_o = sext32(immI);
`endif
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: one-cycle decode with an output register plus a
// single skid entry so upstream may keep streaming while downstream stalls.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  imm_gen_pipe_if.slave bus
);

  logic [XLEN-1:0] decImm;
  imm_fmt_t        decFmt;
  logic            decIllegal;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst_i    (bus.in_inst),
    .imm_o     (decImm),
    .fmt_o     (decFmt),
    .illegal_o (decIllegal)
  );

  logic            outValid_q, outValid_d;
  logic [XLEN-1:0] outImm_q, outImm_d;
  imm_fmt_t        outFmt_q, outFmt_d;
  logic [31:0]     outInst_q, outInst_d;
  logic            outIllegal_q, outIllegal_d;

  logic            skidValid_q, skidValid_d;
  logic [XLEN-1:0] skidImm_q, skidImm_d;
  imm_fmt_t        skidFmt_q, skidFmt_d;
  logic [31:0]     skidInst_q, skidInst_d;
  logic            skidIllegal_q, skidIllegal_d;

  logic accept, loadOut;

  assign accept  = bus.in_valid && !skidValid_q;
  assign loadOut = !outValid_q || bus.out_ready;

  // The skid entry is older than anything arriving now, so it always drains first;
  // in_ready is low whenever the skid is full, so accept and skid drain never coincide.
  always_comb begin
    outValid_d    = outValid_q;
    outImm_d      = outImm_q;
    outFmt_d      = outFmt_q;
    outInst_d     = outInst_q;
    outIllegal_d  = outIllegal_q;
    skidValid_d   = skidValid_q;
    skidImm_d     = skidImm_q;
    skidFmt_d     = skidFmt_q;
    skidInst_d    = skidInst_q;
    skidIllegal_d = skidIllegal_q;
    if (loadOut) begin
      if (skidValid_q) begin
        outValid_d   = 1'b1;
        outImm_d     = skidImm_q;
        outFmt_d     = skidFmt_q;
        outInst_d    = skidInst_q;
        outIllegal_d = skidIllegal_q;
        skidValid_d  = 1'b0;
      end else if (accept) begin
        outValid_d   = 1'b1;
        outImm_d     = decImm;
        outFmt_d     = decFmt;
        outInst_d    = bus.in_inst;
        outIllegal_d = decIllegal;
      end else begin
        outValid_d   = 1'b0;
      end
    end else if (accept) begin
      skidValid_d   = 1'b1;
      skidImm_d     = decImm;
      skidFmt_d     = decFmt;
      skidInst_d    = bus.in_inst;
      skidIllegal_d = decIllegal;
    end
    if (flush_i) begin
      outValid_d  = 1'b0;
      skidValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outValid_q    <= 1'b0;
      outImm_q      <= '0;
      outFmt_q      <= FMT_R;
      outInst_q     <= '0;
      outIllegal_q  <= 1'b0;
      skidValid_q   <= 1'b0;
      skidImm_q     <= '0;
      skidFmt_q     <= FMT_R;
      skidInst_q    <= '0;
      skidIllegal_q <= 1'b0;
    end else begin
      outValid_q    <= outValid_d;
      outImm_q      <= outImm_d;
      outFmt_q      <= outFmt_d;
      outInst_q     <= outInst_d;
      outIllegal_q  <= outIllegal_d;
      skidValid_q   <= skidValid_d;
      skidImm_q     <= skidImm_d;
      skidFmt_q     <= skidFmt_d;
      skidInst_q    <= skidInst_d;
      skidIllegal_q <= skidIllegal_d;
    end
  end

  assign bus.in_ready    = !skidValid_q;
  assign bus.out_valid   = outValid_q;
  assign bus.out_imm     = outImm_q;
  assign bus.out_fmt     = outFmt_q;
  assign bus.out_inst    = outInst_q;
  assign bus.out_illegal = outIllegal_q;

endmodule
